// File: rtl/vram_port_arbiter.sv
// vram_port_arbiter: shares one single-port synchronous VRAM between the
// display scan-out reads and two pixel writers, one access per vga_clock.
// Display reads have fixed priority; writers share leftover slots round-robin,
// and a starvation counter forces a writer through after STARVE_LIMIT
// consecutive denied cycles.
// Optional clear engine, enabled by defining VRAM_CLEAR_EN, sweeps
// CLEAR_WORDS addresses with a colour at the lowest priority.
module vram_port_arbiter #(
    parameter int COLOR_DEPTH  = 9,
    parameter int Mn           = 19,
    parameter int STARVE_LIMIT = 16,
    parameter int CLEAR_WORDS  = 307200
) (
    input  logic                   vga_clock,
    input  logic                   resetn,
    input  logic                   disp_req,
    input  logic [Mn-1:0]          disp_addr,
    output logic [COLOR_DEPTH-1:0] disp_data,
    output logic                   disp_valid,
    output logic                   disp_miss,
    input  logic [1:0]             wr_req,
    input  logic [Mn-1:0]          wr_addr0,
    input  logic [Mn-1:0]          wr_addr1,
    input  logic [COLOR_DEPTH-1:0] wr_data0,
    input  logic [COLOR_DEPTH-1:0] wr_data1,
    output logic [1:0]             wr_ack,
    output logic [Mn-1:0]          mem_addr,
    output logic [COLOR_DEPTH-1:0] mem_wdata,
    output logic                   mem_we,
    input  logic [COLOR_DEPTH-1:0] mem_rdata
`ifdef VRAM_CLEAR_EN
    ,
    input  logic                   clear_start,
    input  logic [COLOR_DEPTH-1:0] clear_color,
    output logic                   clear_busy
`endif
);

    localparam logic [7:0]    STARVE_MAX = 8'(STARVE_LIMIT);
    localparam logic [Mn-1:0] CLEAR_LAST = Mn'(CLEAR_WORDS - 1);

    logic                   rr_q, rr_d;
    logic [7:0]             starve_q, starve_d;
    logic [Mn-1:0]          addr_q, addr_d;
    logic                   disp_valid_q, disp_valid_d;
    logic                   disp_miss_q, disp_miss_d;

    logic                   any_wr, pick, override;
    logic                   disp_grant, wr_grant, clr_grant;
    logic                   we_c;
    logic [1:0]             ack_c;
    logic [COLOR_DEPTH-1:0] wdata_c;

    logic                   clr_run;
    logic [Mn-1:0]          clr_addr;
    logic [COLOR_DEPTH-1:0] clr_color;

    // Grant decision: starvation override, then display, then writers, then clear.
    always_comb begin
        any_wr     = |wr_req;
        // A lone requester wins outright; the pointer only breaks ties.
        pick       = (&wr_req) ? rr_q : wr_req[1];
        override   = any_wr && (starve_q == STARVE_MAX);
        disp_grant = 1'b0;
        wr_grant   = 1'b0;
        clr_grant  = 1'b0;
        if (override) begin
            wr_grant = 1'b1;
        end else if (disp_req) begin
            disp_grant = 1'b1;
        end else if (any_wr) begin
            wr_grant = 1'b1;
        end else if (clr_run) begin
            clr_grant = 1'b1;
        end
    end

    // Memory port mux; idle cycles keep the previous address on the bus.
    always_comb begin
        addr_d  = addr_q;
        we_c    = 1'b0;
        ack_c   = 2'b00;
        wdata_c = '0;
        if (disp_grant) begin
            addr_d = disp_addr;
        end else if (wr_grant) begin
            we_c    = 1'b1;
            ack_c   = pick ? 2'b10 : 2'b01;
            addr_d  = pick ? wr_addr1 : wr_addr0;
            wdata_c = pick ? wr_data1 : wr_data0;
        end else if (clr_grant) begin
            we_c    = 1'b1;
            addr_d  = clr_addr;
            wdata_c = clr_color;
        end
        // Reset blanks the port immediately so an aborted write never lands.
        mem_addr  = resetn ? addr_d  : '0;
        mem_we    = resetn ? we_c    : 1'b0;
        mem_wdata = resetn ? wdata_c : '0;
        wr_ack    = resetn ? ack_c   : 2'b00;
    end

    // Next-state for round-robin pointer, starvation counter and read pipeline.
    always_comb begin
        rr_d         = wr_grant ? ~pick : rr_q;
        starve_d     = starve_q;
        if (wr_grant || !any_wr) begin
            starve_d = '0;
        end else if (starve_q != STARVE_MAX) begin
            starve_d = starve_q + 8'd1;
        end
        disp_valid_d = disp_req && disp_grant;
        disp_miss_d  = disp_req && !disp_grant;
    end

    // Arbiter state registers.
    always_ff @(posedge vga_clock or negedge resetn) begin
        if (!resetn) begin
            rr_q         <= 1'b0;
            starve_q     <= '0;
            addr_q       <= '0;
            disp_valid_q <= 1'b0;
            disp_miss_q  <= 1'b0;
        end else begin
            rr_q         <= rr_d;
            starve_q     <= starve_d;
            addr_q       <= addr_d;
            disp_valid_q <= disp_valid_d;
            disp_miss_q  <= disp_miss_d;
        end
    end

    assign disp_valid = disp_valid_q;
    assign disp_miss  = disp_miss_q;
    assign disp_data  = disp_valid_q ? mem_rdata : '0;

`ifdef VRAM_CLEAR_EN
    localparam logic [0:0] C_IDLE = 1'b0;
    localparam logic [0:0] C_RUN  = 1'b1;

    logic [0:0]             cstate_q, cstate_d;
    logic [Mn-1:0]          ccnt_q, ccnt_d;
    logic [COLOR_DEPTH-1:0] ccolor_q, ccolor_d;

    // Clear sweep: start only from idle, advance one word per granted slot.
    always_comb begin
        cstate_d = cstate_q;
        ccnt_d   = ccnt_q;
        ccolor_d = ccolor_q;
        if (cstate_q == C_IDLE) begin
            if (clear_start) begin
                cstate_d = C_RUN;
                ccnt_d   = '0;
                ccolor_d = clear_color;
            end
        end else if (clr_grant) begin
            if (ccnt_q == CLEAR_LAST) begin
                cstate_d = C_IDLE;
            end else begin
                ccnt_d = ccnt_q + 1'b1;
            end
        end
    end

    // Clear engine registers.
    always_ff @(posedge vga_clock or negedge resetn) begin
        if (!resetn) begin
            cstate_q <= C_IDLE;
            ccnt_q   <= '0;
            ccolor_q <= '0;
        end else begin
            cstate_q <= cstate_d;
            ccnt_q   <= ccnt_d;
            ccolor_q <= ccolor_d;
        end
    end

    assign clr_run    = (cstate_q == C_RUN);
    assign clr_addr   = ccnt_q;
    assign clr_color  = ccolor_q;
    assign clear_busy = clr_run;
`else
    // No clear engine: the lowest-priority source never asks for a slot.
    assign clr_run   = 1'b0;
    assign clr_addr  = CLEAR_LAST;
    assign clr_color = '0;
`endif

endmodule
